// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between a FIFO and its single consumer.
//   fifo_empty : FIFO empty flag (FIFO -> consumer)
//   fifo_data  : FIFO read data, valid while fifo_rd_en is high (FIFO -> consumer)
//   fifo_rd_en : one-cycle pop strobe (consumer -> FIFO)
// modport master : the reading block (drives fifo_rd_en)
// modport slave  : the FIFO side
interface fifo_uart_tx_if #(
    parameter int DW = 8
);
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_en;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx : pops words from a FIFO and serializes them onto a UART line
// (start bit, DW data bits LSB first, optional even parity, STOP_BITS stop bits).
// Ports:
//   CLK        : clock, rising edge
//   RST        : asynchronous active-low reset
//   tx_en      : transmit enable, sampled in IDLE and on the last stop-bit cycle
//   fifo       : FIFO read port (fifo_uart_tx_if.master)
//   tx         : serial output, idles high
//   busy       : high from POP through the last stop-bit cycle
//   frame_done : one-cycle pulse after the final stop-bit cycle
// Build option: define FIFO_UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit(s).
module fifo_uart_tx #(
    parameter int DW           = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int CW           = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  tx_en,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    // bit_idx counts data bits in DATA and stop bits in STOP
    localparam int BW = $clog2(DW + 1);

    localparam logic [CW-1:0] TMAX      = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DW - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_POP    = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;

    logic [2:0]    state_r,   state_s;
    logic [CW-1:0] timer_r,   timer_s;
    logic [BW-1:0] bit_idx_r, bit_idx_s;
    logic [DW-1:0] shift_r,   shift_s;
    logic          done_s;
    logic          bit_end_s;
    logic          tx_r;
    logic          busy_r;
    logic          rd_en_r;
    logic          done_r;

`ifdef FIFO_UART_TX_PARITY_EN
    logic          par_r, par_s;

    function automatic logic parity_even(input logic [DW-1:0] d);
        return ^d;
    endfunction
`endif

    assign bit_end_s = (timer_r == TMAX);

    // Next-state, bit timer, bit index and shift register
    always_comb begin
        state_s   = state_r;
        timer_s   = timer_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        done_s    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        par_s     = par_r;
`endif
        case (state_r)
            S_IDLE: begin
                timer_s   = {CW{1'b0}};
                bit_idx_s = {BW{1'b0}};
                if (tx_en && !fifo.fifo_empty) begin
                    state_s = S_POP;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_POP: begin
                // fifo_data is valid in the pop cycle; capture it on the closing edge
                shift_s   = fifo.fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                par_s     = parity_even(fifo.fifo_data);
`endif
                timer_s   = {CW{1'b0}};
                bit_idx_s = {BW{1'b0}};
                state_s   = S_START;
            end
            S_START: begin
                if (bit_end_s) begin
                    timer_s   = {CW{1'b0}};
                    bit_idx_s = {BW{1'b0}};
                    state_s   = S_DATA;
                end else begin
                    timer_s   = timer_r + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    timer_s = {CW{1'b0}};
                    shift_s = shift_r >> 1;
                    if (bit_idx_r == LAST_DATA) begin
                        bit_idx_s = {BW{1'b0}};
`ifdef FIFO_UART_TX_PARITY_EN
                        state_s   = S_PARITY;
`else
                        state_s   = S_STOP;
`endif
                    end else begin
                        bit_idx_s = bit_idx_r + BW'(1);
                    end
                end else begin
                    timer_s = timer_r + CW'(1);
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end_s) begin
                    timer_s   = {CW{1'b0}};
                    bit_idx_s = {BW{1'b0}};
                    state_s   = S_STOP;
                end else begin
                    timer_s   = timer_r + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end_s) begin
                    timer_s = {CW{1'b0}};
                    if (bit_idx_r == LAST_STOP) begin
                        // last stop-bit cycle: chain straight into the next pop if possible
                        bit_idx_s = {BW{1'b0}};
                        done_s    = 1'b1;
                        if (tx_en && !fifo.fifo_empty) begin
                            state_s = S_POP;
                        end else begin
                            state_s = S_IDLE;
                        end
                    end else begin
                        bit_idx_s = bit_idx_r + BW'(1);
                    end
                end else begin
                    timer_s = timer_r + CW'(1);
                end
            end
            default: begin
                state_s   = S_IDLE;
                timer_s   = {CW{1'b0}};
                bit_idx_s = {BW{1'b0}};
            end
        endcase
    end

    // FSM state registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r   <= S_IDLE;
            timer_r   <= {CW{1'b0}};
            bit_idx_r <= {BW{1'b0}};
            shift_r   <= {DW{1'b0}};
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
        end
    end

`ifdef FIFO_UART_TX_PARITY_EN
    // Parity of the word in flight, captured at pop time
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_r <= 1'b0;
        end else begin
            par_r <= par_s;
        end
    end
`endif

    // Output registers decoded from the next state so they line up with state_r
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            rd_en_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            busy_r  <= (state_s != S_IDLE);
            rd_en_r <= (state_s == S_POP);
            done_r  <= done_s;
            case (state_s)
                S_START: tx_r <= 1'b0;
                S_DATA:  tx_r <= shift_s[0];
`ifdef FIFO_UART_TX_PARITY_EN
                S_PARITY: tx_r <= par_s;
`endif
                default: tx_r <= 1'b1;
            endcase
        end
    end

    assign tx              = tx_r;
    assign busy            = busy_r;
    assign frame_done      = done_r;
    assign fifo.fifo_rd_en = rd_en_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed testbench for fifo_uart_tx (DW=8, CLKS_PER_BIT=16, STOP_BITS=1).
// A small array-based FIFO model feeds the DUT; every expected serial
// waveform is derived from the byte being sent.
module tb_fifo_uart_tx;

    localparam int CPB = 16;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    // POP cycle + start + 8 data + parity + 1 stop
    localparam int FRAME_LEN = 1 + (1 + 8 + PAR + 1) * CPB;

    logic CLK;
    logic RST;
    logic tx_en;
    logic tx;
    logic busy;
    logic frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;

    fifo_uart_tx_if #(.DW(8)) fifo_bus ();

    fifo_uart_tx #(
        .DW(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .CW(8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .tx_en      (tx_en),
        .fifo       (fifo_bus),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign fifo_bus.fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_bus.fifo_data  = mem[rd_ptr % 16];

    always @(posedge CLK) begin
        if (fifo_bus.fifo_rd_en) rd_ptr <= rd_ptr + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr % 16] = d;
        wr_ptr++;
    endtask

    function automatic logic exp_tx(input logic [7:0] b, input int pos);
        int bitn;
        bitn = pos / CPB;
        if (bitn == 0) return 1'b0;
        if (bitn <= 8) return b[bitn-1];
        if (PAR == 1 && bitn == 9) return ^b;
        return 1'b1;
    endfunction

    // Wait (bounded) for the POP cycle, sampled on negedge
    task automatic wait_pop(input string tag);
        int found;
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (fifo_bus.fifo_rd_en === 1'b1) begin
                found = 1;
                break;
            end
        end
        check({tag, " pop seen"}, found, 1);
    endtask

    // Starts at the POP-cycle negedge, ends at the frame_done negedge
    task automatic rx_frame(input string tag, input logic [7:0] b, output logic par_bit);
        int bad;
        logic [7:0] got;
        bad = 0;
        got = 8'h00;
        par_bit = 1'bx;
        check({tag, " pop busy"}, busy, 1);
        for (int c = 1; c < FRAME_LEN; c++) begin
            int pos;
            int bitn;
            @(negedge CLK);
            pos  = c - 1;
            bitn = pos / CPB;
            if (tx !== exp_tx(b, pos) || busy !== 1'b1 ||
                fifo_bus.fifo_rd_en !== 1'b0 || frame_done !== 1'b0) bad++;
            if (pos % CPB == CPB / 2) begin
                if (bitn >= 1 && bitn <= 8) got[bitn-1] = tx;
                if (PAR == 1 && bitn == 9) par_bit = tx;
            end
        end
        check({tag, " waveform errors"}, bad, 0);
        check({tag, " rx byte"}, {24'h0, got}, {24'h0, b});
        @(negedge CLK);
        check({tag, " frame_done"}, frame_done, 1);
    endtask

    initial begin
        logic p;
        int bad_tx;
        int bad_rd;
        int bad_busy;
        int base;

        RST   = 1'b0;
        tx_en = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset tx", tx, 1);
        check("reset busy", busy, 0);
        check("reset rd_en", fifo_bus.fifo_rd_en, 0);
        check("reset frame_done", frame_done, 0);

        // Idle with empty FIFO and tx_en high
        RST   = 1'b1;
        tx_en = 1'b1;
        bad_tx = 0; bad_rd = 0; bad_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (tx !== 1'b1) bad_tx++;
            if (fifo_bus.fifo_rd_en !== 1'b0) bad_rd++;
            if (busy !== 1'b0) bad_busy++;
        end
        check("idle tx", bad_tx, 0);
        check("idle rd_en", bad_rd, 0);
        check("idle busy", bad_busy, 0);

        // Single frame 8'hA5
        push(8'hA5);
        wait_pop("a5");
        rx_frame("a5", 8'hA5, p);
        check("a5 done busy", busy, 0);
        check("a5 done rd_en", fifo_bus.fifo_rd_en, 0);
        @(negedge CLK);
        check("a5 done single pulse", frame_done, 0);
        check("a5 one pop", rd_ptr, 1);

        // Back-to-back frames
        tx_en = 1'b0;
        push(8'h00); push(8'hFF); push(8'h3C);
        repeat (3) @(negedge CLK);
        base  = rd_ptr;
        tx_en = 1'b1;
        wait_pop("b2b0");
        rx_frame("b2b0", 8'h00, p);
        check("b2b pop2 immediate", fifo_bus.fifo_rd_en, 1);
        rx_frame("b2b1", 8'hFF, p);
        check("b2b pop3 immediate", fifo_bus.fifo_rd_en, 1);
        rx_frame("b2b2", 8'h3C, p);
        check("b2b end rd_en", fifo_bus.fifo_rd_en, 0);
        check("b2b end busy", busy, 0);
        @(negedge CLK);
        check("b2b pop count", rd_ptr - base, 3);

        // Enable gating: drop tx_en during DATA with a second word queued
        push(8'h81); push(8'h42);
        wait_pop("gate0");
        fork
            rx_frame("gate0", 8'h81, p);
            begin
                repeat (60) @(negedge CLK);
                tx_en = 1'b0;
            end
        join
        check("gate idle rd_en", fifo_bus.fifo_rd_en, 0);
        check("gate idle busy", busy, 0);
        bad_rd = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (fifo_bus.fifo_rd_en !== 1'b0 || busy !== 1'b0) bad_rd++;
        end
        check("gate held", bad_rd, 0);
        check("gate word kept", fifo_bus.fifo_empty, 0);
        tx_en = 1'b1;
        wait_pop("gate1");
        rx_frame("gate1", 8'h42, p);

        // Parity vectors (waveform always checked; parity bit in parity build)
        @(negedge CLK);
        push(8'h07);
        wait_pop("p07");
        rx_frame("p07", 8'h07, p);
`ifdef FIFO_UART_TX_PARITY_EN
        check("p07 parity", p, 1);
`endif
        @(negedge CLK);
        push(8'h03);
        wait_pop("p03");
        rx_frame("p03", 8'h03, p);
`ifdef FIFO_UART_TX_PARITY_EN
        check("p03 parity", p, 0);
`endif

        // Async reset at data bit 4 of 8'h5A with a second word queued
        @(negedge CLK);
        tx_en = 1'b0;
        push(8'h5A); push(8'h99);
        tx_en = 1'b1;
        wait_pop("rst5a");
        repeat (88) @(negedge CLK);
        check("rst5a bit4 tx", tx, 1);
        check("rst5a busy before", busy, 1);
        #2;
        RST    = 1'b0;
        wr_ptr = rd_ptr;
        #1;
        check("rst async tx", tx, 1);
        check("rst async busy", busy, 0);
        check("rst async rd_en", fifo_bus.fifo_rd_en, 0);
        @(negedge CLK);
        RST = 1'b1;
        bad_rd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (fifo_bus.fifo_rd_en !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) bad_rd++;
        end
        check("post-reset quiet", bad_rd, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the FIFO read port.
- Pops one word whenever the FIFO is non-empty and transmission is enabled.
- Serializes each word onto a single UART-style line: start bit, DW data bits LSB first, stop bit(s).
- Sole reader of its FIFO; it sits between the buffer and the chip pin.

Parameters:
DW, 8, data word width; must match the FIFO data width.
CLKS_PER_BIT, 16, clock cycles per serial bit; minimum 2.
STOP_BITS, 1, number of stop bits; 1 or 2.
CW, 8, bit-timer width; must satisfy 2^CW > CLKS_PER_BIT.

Ports:
CLK  input  1  clock; all state changes on rising edge.
RST  input  1  reset, asynchronous, active-low.
tx_en  input  1  transmit enable; sampled only in IDLE and at end of STOP.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  DW  FIFO read data; valid during the cycle fifo_rd_en is high.
fifo_rd_en  output  1  FIFO pop strobe; exactly one cycle per frame.
tx  output  1  serial line; idles high.
busy  output  1  high from POP through the last stop-bit cycle.
frame_done  output  1  one-cycle pulse in the cycle after the final stop-bit cycle.

Behaviour:
- Reset (RST low, async):
  - State = IDLE; tx = 1; fifo_rd_en = 0; busy = 0; frame_done = 0; bit timer = 0; bit index = 0; shift register = 0.
  - Reset mid-frame aborts the frame immediately; tx returns to 1 asynchronously.
- All outputs are registered or Moore-decoded from state. No combinational path from any input to any output.
- IDLE:
  - tx = 1.
  - If tx_en = 1 and fifo_empty = 0 -> POP next cycle; otherwise stay in IDLE.
- POP (1 cycle):
  - fifo_rd_en = 1, busy = 1.
  - Shift register loads fifo_data on the closing edge.
  - Next state is START. No other state asserts fifo_rd_en.
- START: tx = 0 for CLKS_PER_BIT cycles, then DATA with bit index = 0.
- DATA:
  - tx = shift_reg[0].
  - Every CLKS_PER_BIT cycles: shift right by one and increment bit index.
  - After DW bits -> PARITY if enabled, else STOP.
- STOP:
  - tx = 1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the last cycle: if tx_en = 1 and fifo_empty = 0 -> POP (back-to-back, zero idle cycles between stop and next start bit's POP); otherwise -> IDLE.
- frame_done: asserted one cycle after the last STOP cycle, whichever next state is taken.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1 and resets to 0 on each state/bit change.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
- Frame length (no parity) = 1 POP + (1+DW+STOP_BITS)*CLKS_PER_BIT cycles.
- tx_en dropping mid-frame has no effect until the frame completes; the current word is never lost or truncated.
- fifo_empty is ignored outside IDLE and the last STOP cycle. Because this block is the sole reader, the FIFO cannot go empty between the decision cycle and POP.
- busy = 1 in POP/START/DATA/PARITY/STOP, else 0.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state after DATA: tx = XOR of all DW data bits (even parity) for CLKS_PER_BIT cycles, then STOP.
  - Frame grows by CLKS_PER_BIT cycles.
- Undefined: no PARITY state, no parity logic synthesized; DATA goes directly to STOP.

Test Plan:
- Idle after reset: RST low then high, fifo_empty = 1, tx_en = 1 for 100 cycles -> tx = 1, fifo_rd_en never asserted, busy = 0.
- Single frame (DW=8, CLKS_PER_BIT=16, STOP_BITS=1): push 8'hA5, tx_en = 1.
  - fifo_rd_en high exactly one cycle.
  - tx = 0 for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then 1 for 16 cycles.
  - frame_done pulses once; total 161 cycles POP-through-STOP.
- Back-to-back: preload 8'h00, 8'hFF, 8'h3C -> three contiguous frames with no IDLE cycle between them, three fifo_rd_en pulses, received bytes match in order.
- Enable gating: deassert tx_en during DATA of frame 1 with 2 words queued -> frame 1 completes intact, returns to IDLE, second word is not popped until tx_en = 1 again.
- Async reset mid-frame: drive RST low at bit 4 of 8'h5A -> tx = 1 and busy = 0 without waiting for a clock edge; after release, with the FIFO reset in the same cycle, no pop occurs.
- Parity build (FIFO_UART_TX_PARITY_EN defined):
  - 8'h07 -> parity bit 1.
  - 8'h03 -> parity bit 0.
  - Frame length 177 cycles.
